// File: rtl/fetch_line_buffer_pkg.sv
// Shared definitions for the fetch line buffer.
//   LINE_BYTES / LINE_BITS : I-cache line size (the decode window is one line)
//   WIN_BITS               : bytes a 15-byte offset can reach across two lines
//   fe_state_e             : request FSM encoding
//   line_base()            : aligns an address down to its line
package fetch_line_buffer_pkg;

  localparam int LINE_BYTES = 16;
  localparam int LINE_BITS  = LINE_BYTES * 8;
  localparam int OFS_W      = 4;
  // A 15-byte offset reaches at most byte 30 of the two-line pair, so the
  // last byte of the second line is never presented.
  localparam int WIN_BITS   = (2 * LINE_BYTES - 1) * 8;

  typedef enum logic [1:0] {
    FE_IDLE = 2'd0,
    FE_REQ  = 2'd1,
    FE_DROP = 2'd2
  } fe_state_e;

  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return addr & ~32'h0000_000F;
  endfunction

endpackage

// File: rtl/fetch_line_buffer_if.sv
// Bus bundle of the fetch line buffer: writeback redirect, I-cache line
// request/response, and the decode window with its consume handshake.
//   master : the fetch line buffer itself
//   slave  : the environment (writeback, I-cache, decode)
interface fetch_line_buffer_if;
  import fetch_line_buffer_pkg::*;

  logic                 i_redirect;
  logic [31:0]          i_redirect_eip;
  logic                 o_ic_req;
  logic [31:0]          o_ic_addr;
  logic                 i_ic_ready;
  logic [LINE_BITS-1:0] i_ic_data;
  logic                 o_fe_valid;
  logic [LINE_BITS-1:0] o_fe_bytes;
  logic [31:0]          o_fe_eip;
  logic                 i_de_consume;
  logic [OFS_W-1:0]     i_de_len;

  modport master (
    input  i_redirect, i_redirect_eip, i_ic_ready, i_ic_data,
           i_de_consume, i_de_len,
    output o_ic_req, o_ic_addr, o_fe_valid, o_fe_bytes, o_fe_eip
  );

  modport slave (
    output i_redirect, i_redirect_eip, i_ic_ready, i_ic_data,
           i_de_consume, i_de_len,
    input  o_ic_req, o_ic_addr, o_fe_valid, o_fe_bytes, o_fe_eip
  );

endinterface

// File: rtl/fetch_byte_rotate.sv
// Byte funnel shifter for the decode window.
//   din  : {next line without its top byte, head line}, byte 0 in [7:0]
//   sh   : byte offset into the head line
//   dout : 16 bytes starting at byte sh of din
// Four log stages (1, 2, 4, 8 bytes); each stage keeps only the bits later
// stages can still select.
module fetch_byte_rotate
  import fetch_line_buffer_pkg::*;
(
  input  logic [WIN_BITS-1:0]  din,
  input  logic [OFS_W-1:0]     sh,
  output logic [LINE_BITS-1:0] dout
);

  logic [239:0] s0;
  logic [223:0] s1;
  logic [191:0] s2;

  assign s0   = sh[0] ? din[247:8]  : din[239:0];
  assign s1   = sh[1] ? s0[239:16]  : s0[223:0];
  assign s2   = sh[2] ? s1[223:32]  : s1[191:0];
  assign dout = sh[3] ? s2[191:64]  : s2[127:0];

endmodule

// File: rtl/fetch_line_buffer.sv
// Fetch-stage prefetch buffer. Requests aligned 16-byte lines from the
// I-cache into a two-slot ping-pong buffer and presents a 16-byte window
// starting at the current fetch EIP to decode. A writeback redirect flushes
// both slots and refetches from the new EIP.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : redirect, I-cache request/response, decode window/consume
//
//   state   | meaning
//   FE_IDLE | both slots full, no request
//   FE_REQ  | request for next_addr outstanding
//   FE_DROP | stale request outstanding, its response is discarded
module fetch_line_buffer
  import fetch_line_buffer_pkg::*;
#(
  parameter logic [31:0] RESET_EIP = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_line_buffer_if.master bus
);

  fe_state_e            state;
  logic                 req_q;
  logic [31:0]          next_addr;
  logic [1:0]           slot_vld;
  logic                 head;
  logic [OFS_W-1:0]     offset;
  logic [LINE_BITS-1:0] slot_data [2];
  logic [31:0]          slot_addr [2];

  logic                 nxt;
  logic                 fill_tgt;
  logic                 fill_en;
  logic                 cons_en;
  logic [OFS_W:0]       ofs_sum;
  logic [1:0]           vld_nxt;
  logic [31:0]          addr_inc;

  assign nxt      = ~head;
  // After a flush the head slot is refilled first, so fill order follows
  // line order.
  assign fill_tgt = slot_vld[head] ? nxt : head;
  assign fill_en  = (state == FE_REQ) && bus.i_ic_ready && !bus.i_redirect;
  assign cons_en  = bus.i_de_consume && !bus.i_redirect;
  assign ofs_sum  = {1'b0, offset} + {1'b0, bus.i_de_len};
  assign addr_inc = {next_addr[31:4] + 28'd1, 4'h0};

  always_comb begin
    vld_nxt = slot_vld;
    if (bus.i_redirect) begin
      vld_nxt = 2'b00;
    end else begin
      if (cons_en && ofs_sum[OFS_W]) vld_nxt[head] = 1'b0;
      if (fill_en) vld_nxt[fill_tgt] = 1'b1;
    end
  end

  // FSM, slot valids, head pointer, offset and request address.
  // o_ic_req is registered from the next state, so it reads 0 during reset
  // even though the FSM resets into FE_REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FE_REQ;
      req_q     <= 1'b0;
      next_addr <= line_base(RESET_EIP);
      slot_vld  <= 2'b00;
      head      <= 1'b0;
      offset    <= RESET_EIP[3:0];
    end else begin
      slot_vld <= vld_nxt;

      if (bus.i_redirect) begin
        next_addr <= line_base(bus.i_redirect_eip);
        offset    <= bus.i_redirect_eip[3:0];
      end else begin
        if (fill_en) next_addr <= addr_inc;
        if (cons_en) begin
          offset <= ofs_sum[OFS_W-1:0];
          if (ofs_sum[OFS_W]) head <= nxt;
        end
      end

      unique case (state)
        FE_REQ: begin
          if (bus.i_redirect && !bus.i_ic_ready) begin
            state <= FE_DROP;
            req_q <= 1'b0;
          end else if (!bus.i_redirect && bus.i_ic_ready && (&vld_nxt)) begin
            state <= FE_IDLE;
            req_q <= 1'b0;
          end else begin
            state <= FE_REQ;
            req_q <= 1'b1;
          end
        end
        FE_IDLE: begin
          if (bus.i_redirect || !(&vld_nxt)) begin
            state <= FE_REQ;
            req_q <= 1'b1;
          end else begin
            state <= FE_IDLE;
            req_q <= 1'b0;
          end
        end
        FE_DROP: begin
          // The stale response closes the old request; a redirect while
          // waiting only moves next_addr.
          if (bus.i_ic_ready) begin
            state <= FE_REQ;
            req_q <= 1'b1;
          end else begin
            state <= FE_DROP;
            req_q <= 1'b0;
          end
        end
        default: begin
          state <= FE_REQ;
          req_q <= 1'b1;
        end
      endcase
    end
  end

  // Line storage needs no reset: contents are qualified by slot_vld.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      slot_data[fill_tgt] <= bus.i_ic_data;
      slot_addr[fill_tgt] <= next_addr;
    end
  end

  fetch_byte_rotate u_rotate (
    .din  ({slot_data[nxt][LINE_BITS-9:0], slot_data[head]}),
    .sh   (offset),
    .dout (bus.o_fe_bytes)
  );

  assign bus.o_ic_req   = req_q;
  assign bus.o_ic_addr  = next_addr;
  assign bus.o_fe_valid = slot_vld[head] && ((offset == '0) || slot_vld[nxt]);
  assign bus.o_fe_eip   = slot_addr[head] + {28'd0, offset};

  a_consume_legal: assert property (@(posedge clk) disable iff (!rst_n)
    bus.i_de_consume |-> (bus.o_fe_valid && (bus.i_de_len != 4'd0)));

endmodule

// File: tb/tb_fetch_line_buffer.sv
module tb_fetch_line_buffer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_line_buffer_if bus();

  fetch_line_buffer #(.RESET_EIP(32'h0000_1000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: fetch EIP, number of buffered lines following the
  // line holding the EIP, and whether a discarded request is in flight.
  logic [31:0] m_eip;
  int          m_nlines;
  bit          m_stale;
  bit          m_live;

  // I-cache model: one outstanding request, answered after a delay.
  bit          c_busy;
  logic [31:0] c_addr;
  int          c_cnt;
  int          fixed_delay;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] lo;
    lo = a[7:0] * 8'd29;
    return lo ^ a[15:8] ^ {a[19:16], a[23:20]} ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [127:0] mem_bytes(input logic [31:0] a);
    logic [127:0] l;
    for (int i = 0; i < 16; i++) l[i*8 +: 8] = mem_byte(a + 32'(i));
    return l;
  endfunction

  function automatic bit exp_req();
    return m_live && !m_stale && (m_nlines < 2);
  endfunction

  function automatic logic [31:0] exp_addr();
    return (m_eip & ~32'hF) + 32'(16 * m_nlines);
  endfunction

  function automatic bit exp_valid();
    return (m_nlines >= 1) && ((m_eip[3:0] == 4'd0) || (m_nlines == 2));
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("ic_req", 128'(bus.o_ic_req), 128'(exp_req()));
    if (exp_req()) chk("ic_addr", 128'(bus.o_ic_addr), 128'(exp_addr()));
    chk("fe_valid", 128'(bus.o_fe_valid), 128'(exp_valid()));
    if (exp_valid()) begin
      chk("fe_eip", 128'(bus.o_fe_eip), 128'(m_eip));
      chk("fe_bytes", bus.o_fe_bytes, mem_bytes(m_eip));
    end
  endtask

  // One clock: cache/decode/writeback drive inputs, the model advances, and
  // the DUT is compared half a cycle after the edge.
  task automatic step(input bit rd, input logic [31:0] reip, input bit cons, input logic [3:0] len);
    bit rdy;
    bit cons_ok;
    bit req_now;
    if (!c_busy && bus.o_ic_req) begin
      c_busy = 1'b1;
      c_addr = bus.o_ic_addr;
      c_cnt  = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
    end
    rdy = c_busy && (c_cnt == 0);
    if (c_busy && c_cnt > 0) c_cnt--;
    cons_ok = cons && exp_valid();

    bus.i_redirect     = rd;
    bus.i_redirect_eip = reip;
    bus.i_ic_ready     = rdy;
    bus.i_ic_data      = rdy ? mem_bytes(c_addr) : {$urandom, $urandom, $urandom, $urandom};
    bus.i_de_consume   = cons_ok;
    bus.i_de_len       = len;

    req_now = exp_req();
    if (rd) begin
      m_stale  = (m_stale || req_now) && !rdy;
      m_eip    = reip;
      m_nlines = 0;
    end else begin
      if (rdy) begin
        if (m_stale) m_stale = 1'b0;
        else m_nlines++;
      end
      if (cons_ok) begin
        if (int'(m_eip[3:0]) + int'(len) >= 16) m_nlines--;
        m_eip = m_eip + 32'(len);
      end
    end
    m_live = 1'b1;
    if (rdy) c_busy = 1'b0;

    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 4'd1);
  endtask

  task automatic model_reset();
    m_eip    = 32'h0000_1000;
    m_nlines = 0;
    m_stale  = 1'b0;
    m_live   = 1'b0;
    c_busy   = 1'b0;
    c_cnt    = 0;
    c_addr   = '0;
  endtask

  task automatic clear_inputs();
    bus.i_redirect     = 1'b0;
    bus.i_redirect_eip = '0;
    bus.i_ic_ready     = 1'b0;
    bus.i_ic_data      = '0;
    bus.i_de_consume   = 1'b0;
    bus.i_de_len       = 4'd1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bit rd;
    logic [31:0] reip;

    clear_inputs();
    model_reset();
    fixed_delay = 1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_ic_req", 128'(bus.o_ic_req), 128'(1'b0));
    chk("reset_fe_valid", 128'(bus.o_fe_valid), 128'(1'b0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1) reset fetch from 0x1000, one-cycle cache latency
    idle();
    chk("t1_addr0", 128'(bus.o_ic_addr), 128'(32'h0000_1000));
    idle();
    idle();
    chk("t1_valid", 128'(bus.o_fe_valid), 128'(1'b1));
    chk("t1_eip", 128'(bus.o_fe_eip), 128'(32'h0000_1000));
    chk("t1_addr1", 128'(bus.o_ic_addr), 128'(32'h0000_1010));
    idle();
    idle();
    chk("t1_idle", 128'(bus.o_ic_req), 128'(1'b0));

    // 2) straddling window after redirect to 0x2007
    step(1'b1, 32'h0000_2007, 1'b0, 4'd1);
    chk("t2_addr0", 128'(bus.o_ic_addr), 128'(32'h0000_2000));
    idle();
    idle();
    chk("t2_one_line", 128'(bus.o_fe_valid), 128'(1'b0));
    chk("t2_addr1", 128'(bus.o_ic_addr), 128'(32'h0000_2010));
    idle();
    idle();
    chk("t2_valid", 128'(bus.o_fe_valid), 128'(1'b1));
    chk("t2_eip", 128'(bus.o_fe_eip), 128'(32'h0000_2007));
    chk("t2_byte0", 128'(bus.o_fe_bytes[7:0]), 128'(mem_byte(32'h0000_2007)));
    chk("t2_byte8", 128'(bus.o_fe_bytes[71:64]), 128'(mem_byte(32'h0000_200F)));
    chk("t2_byte9", 128'(bus.o_fe_bytes[79:72]), 128'(mem_byte(32'h0000_2010)));
    chk("t2_byte15", 128'(bus.o_fe_bytes[127:120]), 128'(mem_byte(32'h0000_2016)));

    // 3) consume 9 at offset 7 frees the head line
    step(1'b0, 32'h0, 1'b1, 4'd9);
    chk("t3_eip", 128'(bus.o_fe_eip), 128'(32'h0000_2010));
    chk("t3_valid", 128'(bus.o_fe_valid), 128'(1'b1));
    chk("t3_req", 128'(bus.o_ic_req), 128'(1'b1));
    chk("t3_addr", 128'(bus.o_ic_addr), 128'(32'h0000_2020));

    // 4) redirect while the 0x2020 request is outstanding
    fixed_delay = 2;
    idle();
    step(1'b1, 32'h0000_3000, 1'b0, 4'd1);
    chk("t4_drop_req", 128'(bus.o_ic_req), 128'(1'b0));
    chk("t4_flush", 128'(bus.o_fe_valid), 128'(1'b0));
    idle();
    chk("t4_req", 128'(bus.o_ic_req), 128'(1'b1));
    chk("t4_addr", 128'(bus.o_ic_addr), 128'(32'h0000_3000));
    chk("t4_no_stale", 128'(bus.o_fe_valid), 128'(1'b0));
    fixed_delay = 1;
    idle();
    idle();
    chk("t4_valid", 128'(bus.o_fe_valid), 128'(1'b1));
    chk("t4_byte0", 128'(bus.o_fe_bytes[7:0]), 128'(mem_byte(32'h0000_3000)));

    // 5) redirect, response and consume in the same cycle
    idle();
    step(1'b1, 32'h0000_3000, 1'b1, 4'd4);
    chk("t5_flush", 128'(bus.o_fe_valid), 128'(1'b0));
    chk("t5_req", 128'(bus.o_ic_req), 128'(1'b1));
    chk("t5_addr", 128'(bus.o_ic_addr), 128'(32'h0000_3000));
    idle();
    idle();
    chk("t5_eip", 128'(bus.o_fe_eip), 128'(32'h0000_3000));
    n = 0;
    while (bus.o_ic_req && n < 20) begin
      idle();
      n++;
    end
    chk("t5_idle", 128'(bus.o_ic_req), 128'(1'b0));

    // 6) address wrap
    step(1'b1, 32'hFFFF_FFF8, 1'b0, 4'd1);
    chk("t6_addr0", 128'(bus.o_ic_addr), 128'(32'hFFFF_FFF0));
    idle();
    idle();
    chk("t6_addr1", 128'(bus.o_ic_addr), 128'(32'h0000_0000));
    chk("t6_one_line", 128'(bus.o_fe_valid), 128'(1'b0));
    idle();
    idle();
    chk("t6_valid", 128'(bus.o_fe_valid), 128'(1'b1));
    chk("t6_eip", 128'(bus.o_fe_eip), 128'(32'hFFFF_FFF8));
    chk("t6_byte0", 128'(bus.o_fe_bytes[7:0]), 128'(mem_byte(32'hFFFF_FFF8)));
    chk("t6_byte8", 128'(bus.o_fe_bytes[71:64]), 128'(mem_byte(32'h0000_0000)));

    // Random traffic with a reset in the middle
    fixed_delay = -1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ic_req", 128'(bus.o_ic_req), 128'(1'b0));
        chk("midrst_fe_valid", 128'(bus.o_fe_valid), 128'(1'b0));
        clear_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      rd = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) reip = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
      else reip = $urandom;
      step(rd, reip, ($urandom_range(0, 1) == 1), 4'($urandom_range(1, 15)));
    end

    clear_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
